// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
// Purpose: XLEN, reset/NOP constants and the fetch FSM state enum used by
//          instr_fetch, its memory interface and the pc_next helper.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction-memory request/response bus
// Purpose: groups the fetch request handshake and the response channel.
// Signals:
//   req_valid / req_ready / req_addr : request handshake, fetch address
//   rsp_valid / rsp_data             : returned instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface instr_fetch_if;

  logic                      req_valid;
  logic                      req_ready;
  logic [riscv_pkg::XLEN-1:0] req_addr;
  logic                      rsp_valid;
  logic [riscv_pkg::XLEN-1:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC select and redirect alignment check
// Purpose: computes PC + 4, chooses between sequential and redirect PC and
//          flags a redirect whose target is not word aligned.
// Ports:
//   i_pc         : current PC
//   i_pc_src     : take the redirect
//   i_target     : redirect address
//   o_pc_plus4   : i_pc + 4 (wraps modulo 2^32)
//   o_next_pc    : selected next PC
//   o_misaligned : redirect requested to a non-word-aligned target
module pc_next
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pc_src,
  input  logic [XLEN-1:0] i_target,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  assign o_pc_plus4   = i_pc + 32'd4;
  assign o_next_pc    = i_pc_src ? i_target : o_pc_plus4;
  assign o_misaligned = i_pc_src && (i_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - multi-cycle instruction fetch stage
// Purpose: holds the PC, issues one instruction-memory request at a time,
//          captures the returned word and presents it downstream until it
//          retires; a misaligned redirect parks the stage in a fault state.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   imem          : instruction-memory bus (master side)
//   stall         : downstream cannot retire the presented instruction
//   PCSrc         : take PCTarget when the instruction retires
//   PCTarget      : redirect address
//   Instr, PC     : presented instruction and its address
//   PCPlus4       : PC + 4
//   instr_valid   : Instr/PC valid
//   fetch_fault   : sticky misaligned-redirect fault
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_if.master        imem,
  input  logic                 stall,
  input  logic                 PCSrc,
  input  logic [XLEN-1:0]      PCTarget,
  output logic [XLEN-1:0]      Instr,
  output logic [XLEN-1:0]      PC,
  output logic [XLEN-1:0]      PCPlus4,
  output logic                 instr_valid,
  output logic                 fetch_fault
);

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_instr_valid;
  logic            r_req_valid;
  logic            r_fault;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;
  logic            w_handshake;
  logic            w_rsp_take;
  logic            w_retire;

  pc_next u_pc_next (
    .i_pc         (r_pc),
    .i_pc_src     (PCSrc),
    .i_target     (PCTarget),
    .o_pc_plus4   (w_pc_plus4),
    .o_next_pc    (w_next_pc),
    .o_misaligned (w_misaligned)
  );

  // req_valid is high for exactly the cycles spent in S_REQ.
  assign w_handshake = (r_state == S_REQ) && imem.req_ready;
  // Responses outside S_WAIT are stale or unsolicited and are dropped.
  assign w_rsp_take  = (r_state == S_WAIT) && imem.rsp_valid;
  assign w_retire    = (r_state == S_HOLD) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT:  w_next_state = S_REQ;
      S_REQ:   if (w_handshake) w_next_state = S_WAIT;
      S_WAIT:  if (w_rsp_take) w_next_state = S_HOLD;
      S_HOLD:  if (w_retire) w_next_state = w_misaligned ? S_FAULT : S_REQ;
      S_FAULT: w_next_state = S_FAULT;
      default: w_next_state = S_BOOT;
    endcase
  end

  // Flags are registered from the next state so every output except PCPlus4
  // comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_req_valid   <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_req_valid   <= (w_next_state == S_REQ);
      r_instr_valid <= (w_next_state == S_HOLD);
      if (w_rsp_take) begin
        r_instr <= imem.rsp_data;
      end
      if (w_retire && !w_misaligned) begin
        r_pc <= w_next_pc;
      end
      if (w_retire && w_misaligned) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign imem.req_valid = r_req_valid;
  assign imem.req_addr  = r_pc;
  assign Instr          = r_instr;
  assign PC             = r_pc;
  assign PCPlus4        = w_pc_plus4;
  assign instr_valid    = r_instr_valid;
  assign fetch_fault    = r_fault;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that feeds the decoder and immediate extender. Holds the PC and issues one instruction-memory request at a time.
- Captures the returned word into an instruction register and presents Instr, PC and PCPlus4 downstream.
- Consumes the redirect PCTarget, computed downstream as PC + ImmExt, when PCSrc is asserted at retire.
- Replaces the combinational single-cycle fetch so memories with variable latency can be used.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- NOP_INSTR, 32'h0000_0013, value Instr holds at reset (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address; always equals PC.
- imem_rsp_valid  in  1  response word valid.
- imem_rsp_data  in  32  instruction word.
- stall  in  1  downstream cannot retire the presented instruction this cycle.
- PCSrc  in  1  take the redirect when the current instruction retires.
- PCTarget  in  32  redirect address (PC + ImmExt).
- Instr  out  32  instruction register; bits [31:7] drive the extender.
- PC  out  32  address of Instr.
- PCPlus4  out  32  PC + 4, modulo 2^32.
- instr_valid  out  1  Instr/PC are valid.
- fetch_fault  out  1  sticky misaligned-redirect fault.

Behaviour:
- Reset values: PC = RESET_PC, Instr = NOP_INSTR, instr_valid = 0, imem_req_valid = 0, fetch_fault = 0, state = S_BOOT. All outputs come from registers except PCPlus4, which is PC + 4.
- S_BOOT: lasts one cycle, then goes to S_REQ. imem_req_valid stays 0.
- S_REQ: imem_req_valid = 1 and imem_req_addr = PC.
  - imem_req_valid is held, with a stable address, until imem_req_ready.
  - On valid && ready, go to S_WAIT.
- S_WAIT: imem_req_valid = 0. On imem_rsp_valid, register Instr = imem_rsp_data, set instr_valid = 1, go to S_HOLD. Response latency is unbounded.
- imem_rsp_valid is ignored in every state other than S_WAIT. Stray or post-reset responses are dropped.
- S_HOLD: Instr, PC and instr_valid are held while stall = 1.
- Retire (S_HOLD && !stall):
  - instr_valid falls next cycle.
  - If PCSrc = 1 and PCTarget[1:0] == 0: PC = PCTarget, go to S_REQ.
  - If PCSrc = 0: PC = PCPlus4, go to S_REQ.
  - If PCSrc = 1 and PCTarget[1:0] != 0: PC unchanged, fetch_fault = 1, go to S_FAULT.
- PCSrc and PCTarget are sampled only in the retire cycle; they are don't-care otherwise.
- S_FAULT: terminal. No requests, instr_valid = 0, fetch_fault held at 1. Exit only via rst_n.
- Best-case throughput: one instruction per 3 cycles (request, response, retire).
  - Cycle N: request handshake.
  - Cycle N+1 (earliest): response.
  - Cycle N+2: instr_valid = 1; retire if stall = 0.
  - Cycle N+3: next request.
- PC wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no fault.
- At most one outstanding request; a second request is never issued before the response arrives.
- Reset asserted mid-transaction (S_REQ/S_WAIT/S_HOLD) immediately forces the reset values. A response to the aborted request that arrives later is ignored, because the FSM passes through S_BOOT/S_REQ before S_WAIT.
- Simultaneous stall = 1 and PCSrc = 1 in S_HOLD: no retire, no redirect, PC unchanged.

Decomposition:
- Shared package (riscv_pkg): fetch state enum (S_BOOT, S_REQ, S_WAIT, S_HOLD, S_FAULT), NOP_INSTR constant, default RESET_PC, and XLEN = 32.
- One sub-module, pc_next: combinational next-PC select (PCPlus4 vs PCTarget) plus misalignment detect. The FSM and registers stay in instr_fetch.

Test Plan:
- Reset release, ready = 1, response 1 cycle after request with data 32'h0050_0093 → first request at cycle 2 after rst_n rises with addr 0; instr_valid = 1 with Instr = 32'h0050_0093, PC = 0, PCPlus4 = 4; next request addr = 4.
- imem_req_ready low for 4 cycles → imem_req_valid held at 1 and addr stable at 4 throughout; exactly one handshake.
- Retire with PCSrc = 1, PCTarget = 32'h0000_0100 → next imem_req_addr = 32'h100. Repeat with stall = 1 for 3 cycles first → Instr/PC unchanged during stall; redirect taken only on the stall = 0 cycle.
- PCSrc = 1, PCTarget = 32'h0000_0102 → fetch_fault = 1 next cycle; no further imem_req_valid for 20 cycles; cleared only by rst_n.
- rst_n pulsed low while in S_WAIT, then a stale imem_rsp_valid with data 32'hDEAD_BEEF arrives 1 cycle after release → ignored; Instr stays NOP_INSTR; fetch restarts at RESET_PC.
- PC at 32'hFFFF_FFFC, retire with PCSrc = 0 → next request addr = 32'h0000_0000, fetch_fault = 0.
